// File: rtl/matmul_host_ctrl.sv
// matmul_host_ctrl
// Host-side initiator for the 8x8 systolic matrix-multiplication block.
// Loads A then B rows from an input stream into the A/B BRAMs, runs the
// multiply until done_mat_mul, then reads C back through a 3-entry output
// FIFO onto a valid/ready output stream.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   go, abort                        job start (IDLE only) / return to IDLE
//   in_valid/in_ready/in_data        A-then-B row stream (4*DWIDTH)
//   out_valid/out_ready/out_data     C row stream (4*DWIDTH)
//   busy, done, err                  status: not idle / last pop / timeout
//   enable_writing_to_mem, enable_reading_from_mem,
//   we_a, we_b, we_c, start_mat_mul  registered memory/control strobes
//   addr_pi, data_pi                 registered BRAM address / write data
//   done_mat_mul                     compute complete
//   data_from_out_mat                C read data, 1 cycle after addr_pi
module matmul_host_ctrl #(
  parameter int DWIDTH         = 16,
  parameter int AWIDTH         = 7,
  parameter int NUM_A_WORDS    = 8,
  parameter int NUM_B_WORDS    = 8,
  parameter int NUM_C_WORDS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DWIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DWIDTH-1:0] out_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                enable_writing_to_mem,
  output logic                enable_reading_from_mem,
  output logic                we_a,
  output logic                we_b,
  output logic                we_c,
  output logic                start_mat_mul,
  output logic [AWIDTH-1:0]   addr_pi,
  output logic [4*DWIDTH-1:0] data_pi,
  input  logic                done_mat_mul,
  input  logic [4*DWIDTH-1:0] data_from_out_mat
);

  localparam int WW    = 4 * DWIDTH;
  localparam int MAXW0 = (NUM_A_WORDS > NUM_B_WORDS) ? NUM_A_WORDS : NUM_B_WORDS;
  localparam int MAXW  = (MAXW0 > NUM_C_WORDS) ? MAXW0 : NUM_C_WORDS;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] LAST_A   = CW'(NUM_A_WORDS - 1);
  localparam logic [CW-1:0] LAST_B   = CW'(NUM_B_WORDS - 1);
  localparam logic [CW-1:0] LAST_C   = CW'(NUM_C_WORDS - 1);
  localparam logic [CW-1:0] NUM_C    = CW'(NUM_C_WORDS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_COMPUTE, S_DRAIN, S_ERR
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;       // load word index
  logic [CW-1:0]     r_rd_cnt;    // C reads issued
  logic [CW-1:0]     r_pop_cnt;   // C words delivered
  logic [TW-1:0]     r_tmo;
  logic              r_err, r_en_wr, r_en_rd, r_we_a, r_we_b, r_we_c, r_start;
  logic [AWIDTH-1:0] r_addr;
  logic [WW-1:0]     r_data;
  logic              r_rd_issue;  // addr_pi currently carries a C read
  logic              r_rd_pend;   // data_from_out_mat carries read data now
  logic [WW-1:0]     r_fifo [3];
  logic [1:0]        r_wr_ptr, r_rd_ptr, r_fcnt;

  logic       w_pop, w_push, w_issue;
  logic [2:0] w_committed;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    w_pop  = (r_fcnt != 2'd0) && out_ready;
    w_push = r_rd_pend;
    // FIFO slots already spoken for after this cycle's pop; a new read is
    // only issued while that stays below the 3-entry depth, so data that is
    // in flight always has somewhere to land even if out_ready stays low.
    w_committed = 3'(r_fcnt) - 3'(w_pop) + 3'(r_rd_issue) + 3'(r_rd_pend);
    w_issue = (r_state == S_DRAIN) && (r_rd_cnt < NUM_C) && (w_committed < 3'd3);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd_cnt   <= '0;
      r_pop_cnt  <= '0;
      r_tmo      <= '0;
      r_err      <= 1'b0;
      r_en_wr    <= 1'b0;
      r_en_rd    <= 1'b0;
      r_we_a     <= 1'b0;
      r_we_b     <= 1'b0;
      r_we_c     <= 1'b0;
      r_start    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rd_issue <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fcnt     <= '0;
      // NOTE: the FIFO storage is reset because its head drives out_data,
      // which must read 0 out of reset; it is only three words.
      for (int i = 0; i < 3; i++) r_fifo[i] <= '0;
    end else if (abort) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd_cnt   <= '0;
      r_pop_cnt  <= '0;
      r_tmo      <= '0;
      r_err      <= 1'b0;
      r_en_wr    <= 1'b0;
      r_en_rd    <= 1'b0;
      r_we_a     <= 1'b0;
      r_we_b     <= 1'b0;
      r_we_c     <= 1'b0;
      r_start    <= 1'b0;
      r_rd_issue <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fcnt     <= '0;
      for (int i = 0; i < 3; i++) r_fifo[i] <= '0;
    end else begin
      // Strobes are single-cycle unless the current state re-asserts them.
      r_en_wr    <= 1'b0;
      r_en_rd    <= 1'b0;
      r_we_a     <= 1'b0;
      r_we_b     <= 1'b0;
      r_we_c     <= 1'b0;
      r_start    <= 1'b0;
      r_rd_issue <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state <= S_LOAD_A;
            r_cnt   <= '0;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (in_valid) begin
            r_en_wr <= 1'b1;
            r_we_a  <= (r_state == S_LOAD_A);
            r_we_b  <= (r_state == S_LOAD_B);
            r_addr  <= AWIDTH'(r_cnt);
            r_data  <= in_data;
            if (r_state == S_LOAD_A && r_cnt == LAST_A) begin
              r_state <= S_LOAD_B;
              r_cnt   <= '0;
            end else if (r_state == S_LOAD_B && r_cnt == LAST_B) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_START: begin
          r_state <= S_COMPUTE;
          r_start <= 1'b1;
          r_we_c  <= 1'b1;
          r_tmo   <= '0;
        end
        S_COMPUTE: begin
          if (done_mat_mul) begin
            r_state   <= S_DRAIN;
            r_en_rd   <= 1'b1;
            r_rd_cnt  <= '0;
            r_pop_cnt <= '0;
          end else if (r_tmo == TMO_LAST) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_start <= 1'b1;
            r_we_c  <= 1'b1;
            r_tmo   <= r_tmo + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_pop && r_pop_cnt == LAST_C) begin
            r_state <= S_IDLE;
          end else begin
            r_en_rd <= 1'b1;
          end
          if (w_issue) begin
            r_addr     <= AWIDTH'(r_rd_cnt);
            r_rd_issue <= 1'b1;
            r_rd_cnt   <= r_rd_cnt + 1'b1;
          end
        end
        S_ERR: ;
        default: r_state <= S_IDLE;
      endcase

      // Read pipeline and output FIFO.
      r_rd_pend <= r_rd_issue;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= data_from_out_mat;
        r_wr_ptr         <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr  <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
        r_pop_cnt <= r_pop_cnt + 1'b1;
      end
      r_fcnt <= r_fcnt + 2'(w_push) - 2'(w_pop);
    end
  end

  assign in_ready                = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign busy                    = (r_state != S_IDLE);
  assign out_valid               = (r_fcnt != 2'd0);
  assign out_data                = r_fifo[r_rd_ptr];
  assign done                    = (r_state == S_DRAIN) && w_pop && (r_pop_cnt == LAST_C);
  assign err                     = r_err;
  assign enable_writing_to_mem   = r_en_wr;
  assign enable_reading_from_mem = r_en_rd;
  assign we_a                    = r_we_a;
  assign we_b                    = r_we_b;
  assign we_c                    = r_we_c;
  assign start_mat_mul           = r_start;
  assign addr_pi                 = r_addr;
  assign data_pi                 = r_data;

endmodule

// File: tb/tb_matmul_host_ctrl.sv
// tb_matmul_host_ctrl
// Directed bench for matmul_host_ctrl. A small memory model stands in for
// the matrix_multiplication block: it stores A/B writes, forms a 4x4 product
// from A words 0..3 and B words 0..3 when done_mat_mul is pulsed, and returns
// C words one cycle after addr_pi. Inputs change 1 time unit after the rising
// edge; outputs are observed on the falling edge.
module tb_matmul_host_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 7;
  localparam int WW  = 4 * DW;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic          done_mat_mul = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic [WW-1:0] data_from_out_mat = '0;
  logic          in_ready, out_valid, busy, done, err;
  logic          enable_writing_to_mem, enable_reading_from_mem;
  logic          we_a, we_b, we_c, start_mat_mul;
  logic [AW-1:0] addr_pi;
  logic [WW-1:0] data_pi, out_data;

  matmul_host_ctrl #(
    .DWIDTH(DW), .AWIDTH(AW), .NUM_A_WORDS(8), .NUM_B_WORDS(8),
    .NUM_C_WORDS(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err(err),
    .enable_writing_to_mem(enable_writing_to_mem),
    .enable_reading_from_mem(enable_reading_from_mem),
    .we_a(we_a), .we_b(we_b), .we_c(we_c), .start_mat_mul(start_mat_mul),
    .addr_pi(addr_pi), .data_pi(data_pi),
    .done_mat_mul(done_mat_mul), .data_from_out_mat(data_from_out_mat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int c_cyc = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- memory model ----------------
  logic [WW-1:0] mem_a [128];
  logic [WW-1:0] mem_b [128];
  logic [WW-1:0] mem_c [128];

  function automatic logic [WW-1:0] c_word(input int k);
    logic [15:0]   acc;
    logic [WW-1:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      acc = '0;
      for (int i = 0; i < 4; i++)
        acc = acc + 16'(mem_a[k][16*i +: 16] * mem_b[i][16*j +: 16]);
      r[16*j +: 16] = acc;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (enable_writing_to_mem && we_a) mem_a[addr_pi] <= data_pi;
    if (enable_writing_to_mem && we_b) mem_b[addr_pi] <= data_pi;
    if (done_mat_mul) for (int k = 0; k < 4; k++) mem_c[k] <= c_word(k);
    data_from_out_mat <= mem_c[addr_pi];
  end

  // ---------------- monitor ----------------
  typedef struct {
    logic          is_b;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  wr_t           wr_log[$];
  logic [WW-1:0] pop_log[$];
  int            pop_cyc[$];
  logic          hs_prev = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (we_a || we_b) begin
        wr_log.push_back('{is_b: we_b, addr: addr_pi, data: data_pi});
        check("write_follows_handshake", 64'(hs_prev), 64'd1);
        check("write_enable_with_we", 64'(enable_writing_to_mem), 64'd1);
      end
      if (out_valid && out_ready) begin
        pop_log.push_back(out_data);
        pop_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        check("done_on_final_pop", 64'(out_valid && out_ready && pop_log.size() == 4), 64'd1);
      end
      hs_prev = in_valid && in_ready;
    end else begin
      hs_prev = 1'b0;
    end
  end

  // ---------------- vector tables ----------------
  typedef struct {
    logic [WW-1:0] din;
    logic          exp_b;
    logic [AW-1:0] exp_addr;
  } wvec_t;

  wvec_t         wtab[16];
  logic [WW-1:0] ctab[4];

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    pop_log.delete();
    pop_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic start_job();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic stream(input int n, input bit bubbles);
    int i;
    bit ph;
    i  = 0;
    ph = 1'b1;
    for (int g = 0; g < 200 && i < n; g++) begin
      in_data  = wtab[i].din;
      in_valid = bubbles ? ph : 1'b1;
      ph       = ~ph;
      @(negedge clk);
      if (in_valid && in_ready) i++;
      step();
    end
    in_valid = 1'b0;
    check("stream_words_accepted", 64'(i), 64'(n));
  endtask

  task automatic finish_compute(input int n);
    repeat (n) step();
    done_mat_mul = 1'b1;
    c_cyc = cyc;
    @(negedge clk);
    check("start_held_in_compute", 64'(start_mat_mul), 64'd1);
    check("we_c_in_compute", 64'(we_c), 64'd1);
    check("no_write_enable_in_compute", 64'(enable_writing_to_mem), 64'd0);
    step();
    done_mat_mul = 1'b0;
    @(negedge clk);
    check("start_low_after_done", 64'(start_mat_mul), 64'd0);
    check("we_c_low_after_done", 64'(we_c), 64'd0);
    check("read_enable_in_drain", 64'(enable_reading_from_mem), 64'd1);
    step();
  endtask

  task automatic wait_pops(input int n);
    for (int g = 0; g < 100 && pop_log.size() < n; g++) step();
    check("pops_delivered", 64'(pop_log.size()), 64'(n));
  endtask

  task automatic check_writes(input int n);
    check("write_count", 64'(wr_log.size()), 64'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      check("write_bank", 64'(wr_log[i].is_b), 64'(wtab[i].exp_b));
      check("write_addr", 64'(wr_log[i].addr), 64'(wtab[i].exp_addr));
      check("write_data", wr_log[i].data, wtab[i].din);
    end
  endtask

  task automatic check_results();
    check("c_word_count", 64'(pop_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++)
      check("c_word", pop_log[i], ctab[i]);
    check("done_pulses", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, out_data, 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_strobes"}, 64'({enable_writing_to_mem, enable_reading_from_mem,
                                   we_a, we_b, we_c, start_mat_mul}), 64'd0);
    check({tag, "_addr_pi"}, 64'(addr_pi), 64'd0);
    check({tag, "_data_pi"}, data_pi, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ph;
    int hi;

    for (int i = 0; i < 8; i++) begin
      wtab[i]     = '{din: {4{16'(i + 1)}}, exp_b: 1'b0, exp_addr: AW'(i)};
      wtab[8 + i] = '{din: {4{16'(16'h11 + i)}}, exp_b: 1'b1, exp_addr: AW'(i)};
    end
    // A row k = (k+1) in every lane, B row i = 0x11+i in every lane:
    // C[k][j] = (k+1) * (0x11+0x12+0x13+0x14) = (k+1) * 0x4A.
    ctab = '{{4{16'h004A}}, {4{16'h0094}}, {4{16'h00DE}}, {4{16'h0128}}};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    step();

    // ---- full job, in_valid and out_ready always high ----
    clear_logs();
    out_ready = 1'b1;
    start_job();
    stream(16, 1'b0);
    @(negedge clk);
    check("start_cycle_start_low", 64'(start_mat_mul), 64'd0);
    check("start_cycle_last_b_write", 64'({we_b, addr_pi}), 64'({1'b1, 7'd7}));
    check("start_cycle_in_ready", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    check("start_rises_two_after_last_b", 64'(start_mat_mul), 64'd1);
    step();
    finish_compute(2);
    wait_pops(4);
    @(negedge clk);
    check("busy_low_after_done", 64'(busy), 64'd0);
    step();
    check_writes(16);
    check_results();
    if (pop_cyc.size() == 4) begin
      check("first_word_latency", 64'(pop_cyc[0] - c_cyc), 64'd4);
      check("one_word_per_cycle", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
    end

    // ---- input bubbles + output backpressure ----
    clear_logs();
    out_ready = 1'b0;
    start_job();
    stream(16, 1'b1);
    step();
    finish_compute(2);
    repeat (8) step();
    @(negedge clk);
    check("bp_out_valid_held", 64'(out_valid), 64'd1);
    check("bp_three_reads_only", 64'(addr_pi), 64'd2);
    check("bp_no_pop", 64'(pop_log.size()), 64'd0);
    check("bp_head_word", out_data, ctab[0]);
    step();
    ph = 1'b1;
    for (int g = 0; g < 60 && pop_log.size() < 4; g++) begin
      out_ready = ph;
      ph        = ~ph;
      step();
    end
    out_ready = 1'b0;
    step();
    check("bp_idle_after_job", 64'(busy), 64'd0);
    check_writes(16);
    check_results();

    // ---- COMPUTE timeout ----
    clear_logs();
    start_job();
    stream(16, 1'b0);
    hi = 0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (err) break;
      if (start_mat_mul) hi++;
      step();
    end
    check("tmo_compute_cycles", 64'(hi), 64'(TMO));
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_start_low", 64'(start_mat_mul), 64'd0);
    check("tmo_we_c_low", 64'(we_c), 64'd0);
    check("tmo_busy", 64'(busy), 64'd1);
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    @(negedge clk);
    check("tmo_go_ignored", 64'({busy, err, in_ready}), 64'({1'b1, 1'b1, 1'b0}));
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("tmo_abort_idle", 64'(busy), 64'd0);
    check("tmo_abort_err_clear", 64'(err), 64'd0);
    step();

    // ---- abort mid-LOAD_B together with go ----
    clear_logs();
    start_job();
    stream(11, 1'b0);
    abort = 1'b1;
    go    = 1'b1;
    step();
    abort = 1'b0;
    go    = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_strobes", 64'({enable_writing_to_mem, we_a, we_b, we_c, start_mat_mul}), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    check("abort_go_ignored", 64'(busy), 64'd0);
    step();
    check_writes(11);
    clear_logs();
    start_job();
    stream(1, 1'b0);
    step();
    check("restart_one_write", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() > 0)
      check("restart_a_addr0", 64'({wr_log[0].is_b, wr_log[0].addr}), 64'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // ---- async reset mid-DRAIN ----
    clear_logs();
    out_ready = 1'b0;
    start_job();
    stream(16, 1'b0);
    step();
    finish_compute(2);
    repeat (4) step();
    @(negedge clk);
    check("drain_words_waiting", 64'(out_valid), 64'd1);
    #2;
    reset_n   = 1'b0;
    out_ready = 1'b1;
    #1;
    check_zero("async_reset");
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check("reset_no_done", 64'(done_cnt), 64'd0);
    check("reset_still_idle", 64'(busy), 64'd0);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_host_ctrl.md
# matmul_host_ctrl

Host-side initiator for the 8x8 systolic matrix-multiplication top level. It accepts A and B rows from a valid/ready input stream, writes them into the A/B BRAMs through the shared `addr_pi`/`data_pi` port, and runs the multiply by holding `start_mat_mul` until `done_mat_mul`. It then reads the C BRAMs back and emits the result words on a valid/ready output stream. It sits between the system fabric and `matrix_multiplication`, driving every host-facing port of that block.

## Interface
- `DWIDTH`, 16, element width; stream and memory words are 4*DWIDTH bits
- `AWIDTH`, 7, BRAM address width
- `NUM_A_WORDS`, 8, words written with `we_a`
- `NUM_B_WORDS`, 8, words written with `we_b`
- `NUM_C_WORDS`, 4, words read back
- `TIMEOUT_CYCLES`, 1024, maximum COMPUTE cycles before error
- `clk`  in  1  clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `go`  in  1  start a job; sampled only in IDLE
- `abort`  in  1  return to IDLE from any state
- `in_valid` / `in_ready` / `in_data`  in / out / in  1 / 1 / 4*DWIDTH  A-then-B row stream
- `out_valid` / `out_ready` / `out_data`  out / in / out  1 / 1 / 4*DWIDTH  C row stream
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse when the last C word is accepted
- `err`  out  1  sticky COMPUTE timeout flag
- `enable_writing_to_mem`, `enable_reading_from_mem`, `we_a`, `we_b`, `we_c`, `start_mat_mul`  out  1 each  memory and control strobes, all registered
- `addr_pi`  out  AWIDTH  registered BRAM address
- `data_pi`  out  4*DWIDTH  registered write data
- `done_mat_mul`  in  1  compute complete
- `data_from_out_mat`  in  4*DWIDTH  C read data, valid 1 cycle after address

## Operation
- States: IDLE, LOAD_A, LOAD_B, START, COMPUTE, DRAIN, ERR.
- IDLE: `in_ready`=0. On `go` -> LOAD_A, with word counter set to 0.
- LOAD_A / LOAD_B: `in_ready`=1.
  - Each handshake registers `addr_pi`=counter, `data_pi`=`in_data`, `we_a` (or `we_b`)=1 and `enable_writing_to_mem`=1 for exactly the next cycle.
  - With no handshake, `we_*`=0 next cycle.
  - The accept of word NUM_A_WORDS-1 -> LOAD_B with counter cleared. The accept of word NUM_B_WORDS-1 -> START.
- START: one cycle. The last B write is on the ports. `in_ready`=0.
- COMPUTE: `start_mat_mul`=1, `we_c`=1, `enable_writing_to_mem`=0. A timeout counter increments each cycle.
  - `done_mat_mul`=1 -> DRAIN. `start_mat_mul` and `we_c` are 0 from the next cycle.
  - Counter reaches TIMEOUT_CYCLES -> ERR with `err`=1.
- DRAIN:
  - `enable_reading_from_mem`=1.
  - A read of address k (0..NUM_C_WORDS-1) is issued only when FIFO occupancy + reads in flight < 3.
  - Returned data is captured into a 3-entry output FIFO. `out_valid` = FIFO non-empty; `out_data` = FIFO head.
  - When the NUM_C_WORDS-th word is popped: `done` pulses and the next state is IDLE.
- ERR: all strobes 0, `in_ready`=0, `busy`=1. Leaves only on `abort` or reset.
- `abort` in any state: next state IDLE, FIFO and counters cleared, all strobes 0, `err` cleared. `abort` wins over a simultaneous `go`.
- `go` is ignored outside IDLE.
- `addr_pi` holds its last value when no access is active, and is 0 after reset.

## Timing
- Reset value 0 for every output, including `addr_pi`, `data_pi` and `out_data`. State is IDLE.
- Write latency: a handshake at cycle t puts the write on the ports at t+1.
- Last B handshake at t: START at t+1, `start_mat_mul` rises at t+2.
- `done_mat_mul` high at cycle c: `start_mat_mul` and `we_c` low at c+1. DRAIN is entered at c+1.
- DRAIN entry at d with `out_ready` held high:
  - `addr_pi`=0 read at d+1, data captured at the end of d+2, `out_valid` at d+3.
  - One word per cycle thereafter.
- With `out_ready` low, at most 3 words are outstanding. No read is issued that could overflow the FIFO, and no word is dropped or duplicated.
- `done` is asserted in the same cycle as the final `out_valid && out_ready`. `busy` falls the next cycle.

## Test plan
- Full job: `go`; stream A words 0x0001..0x0008 (replicated lanes) and B words 0x0011..0x0018 with `in_valid` always high. Required:
  - `we_a` high with `addr_pi` 0..7.
  - `we_b` high with `addr_pi` 0..7.
  - `start_mat_mul` rises 2 cycles after the last B accept.
  - The 4 C words match the reference product in address order; `done` pulses once.
- Input bubbles: drop `in_valid` every other cycle -> exactly 16 writes, addresses contiguous, no write while `in_valid`=0.
- Output backpressure: `out_ready` low for 10 cycles at DRAIN entry, then toggling -> `out_valid` held, at most 3 reads issued before the first pop, all 4 words delivered once in order.
- Timeout: `TIMEOUT_CYCLES`=16 and `done_mat_mul` tied low -> `err`=1 after 16 COMPUTE cycles with `start_mat_mul`=0. `abort` -> IDLE and `err`=0.
- Abort mid-LOAD_B after 3 B words (same cycle as `go`) -> IDLE next cycle, all strobes 0, `go` ignored. A subsequent `go` restarts at A address 0.
- Async reset asserted mid-DRAIN -> all outputs 0 immediately, `busy`=0, no `done` pulse.
